// File: rtl/instr_issue_queue.sv
// Purpose : host instruction FIFO that issues one instruction at a time to the
//           matrix-unit control FSM and drives NOP (8'h00) between issues.
// Latency : push at edge N into an empty queue with the FSM idle gives
//           host_instruction valid after edge N+1. It is held for ISSUE_HOLD
//           cycles and returns to NOP from edge N+1+ISSUE_HOLD.
// Backpressure: host_ready = !full, taken from the registered count. A pop in
//           the same cycle does not free a slot for that cycle's push.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   host_instr/valid    host instruction {dst[1:0],src[1:0],op[3:0]} and its valid
//   host_ready          queue can accept this cycle
//   flush               synchronous queue clear (in-flight instruction unaffected)
//   fsm_busy            busy flag from the control FSM
//   host_instruction    registered instruction to the FSM (NOP when not issuing)
//   count/empty/full    queue occupancy
//   timeout_err         sticky: the FSM never went busy after an issue
module instr_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int ISSUE_HOLD   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   host_instr,
  input  logic                         host_valid,
  output logic                         host_ready,
  input  logic                         flush,
  input  logic                         fsm_busy,
  output logic [7:0]                   host_instruction,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(ISSUE_HOLD + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(ISSUE_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_IDLE = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] wait_cnt;
  logic          seen_busy;
  logic          push;
  logic          pop;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign host_ready = !full;

  // NOP instructions are handshaken but never stored; a flush drops any push.
  assign push = host_valid && host_ready && (host_instr != 8'h00) && !flush;
  // The issuer only sees registered occupancy, so nothing bypasses the FIFO.
  assign pop  = (state == S_IDLE) && !empty && !fsm_busy;

  // Queue pointers and occupancy. Pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= host_instr;
  end

  // Issue sequencer. wait_cnt counts edges since the issue so the busy timeout
  // spans both the hold window and the wait for busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      host_instruction <= 8'h00;
      hold_cnt         <= '0;
      wait_cnt         <= '0;
      seen_busy        <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            host_instruction <= mem[rptr];
            hold_cnt         <= HOLD_INIT;
            wait_cnt         <= '0;
            seen_busy        <= 1'b0;
            state            <= S_ISSUE;
          end else begin
            host_instruction <= 8'h00;
          end
        end
        S_ISSUE: begin
          hold_cnt <= hold_cnt - HW'(1);
          wait_cnt <= wait_cnt + TW'(1);
          // The FSM may react while the instruction is still held; remember it
          // so a short busy pulse is not mistaken for a timeout.
          if (fsm_busy) seen_busy <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            host_instruction <= 8'h00;
            state            <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (fsm_busy || seen_busy) begin
            seen_busy <= 1'b0;
            state     <= S_WAIT_IDLE;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (!fsm_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: the driver pushes accepted entries
// into a reference queue, a monitor pops and checks on every new issue, and a
// small FSM model drives fsm_busy in response to issued instructions.
module tb_instr_issue_queue;
  localparam int DEPTH        = 8;
  localparam int ISSUE_HOLD   = 2;
  localparam int BUSY_TIMEOUT = 4;
  localparam int CW           = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    host_instr = 8'h00;
  logic          host_valid = 1'b0;
  logic          flush = 1'b0;
  logic          fsm_busy = 1'b0;
  logic          host_ready;
  logic [7:0]    host_instruction;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          timeout_err;

  instr_issue_queue #(
    .DEPTH(DEPTH), .ISSUE_HOLD(ISSUE_HOLD), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .host_instr(host_instr), .host_valid(host_valid),
    .host_ready(host_ready), .flush(flush), .fsm_busy(fsm_busy),
    .host_instruction(host_instruction), .count(count), .empty(empty),
    .full(full), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored entries in FIFO order plus sticky timeout.
  logic [7:0] sb[$];
  bit         exp_timeout = 1'b0;
  bit         flush_pending = 1'b0;
  bit         armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] prev_instr = 8'h00;
  int         run = 0;
  int         since = 0;
  bit         tracking = 1'b0;
  bit         saw = 1'b0;

  always begin
    @(posedge clk); #1;
    if (!reset) begin
      armed = 1'b1;
      sb.delete();
      exp_timeout = 1'b0;
      flush_pending = 1'b0;
      tracking = 1'b0;
      run = 0;
      prev_instr = 8'h00;
      check("rst_instr", host_instruction, 8'h00);
      check("rst_count", count, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_ready", host_ready, 1);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
    end else if (armed) begin
      if (host_instruction != 8'h00 && prev_instr == 8'h00) begin
        // A new issue: the FSM must have been idle and the head must match.
        check("issue_busy_low", fsm_busy, 0);
        if (sb.size() == 0) check("issue_unexpected", host_instruction, 8'h00);
        else check("issue_order", host_instruction, sb.pop_front());
        tracking = 1'b1;
        since = 0;
        saw = 1'b0;
        run = 1;
      end else begin
        if (tracking) begin
          since++;
          if (fsm_busy) saw = 1'b1;
          if (since == BUSY_TIMEOUT) begin
            tracking = 1'b0;
            if (!saw) exp_timeout = 1'b1;
          end
        end
        if (host_instruction != 8'h00) begin
          check("hold_stable", host_instruction, prev_instr);
          run++;
        end else if (prev_instr != 8'h00) begin
          check("hold_len", run, ISSUE_HOLD);
          run = 0;
        end
      end
      if (flush_pending) begin
        sb.delete();
        flush_pending = 1'b0;
      end
      check("count", count, sb.size());
      check("empty", empty, sb.size() == 0);
      check("full", full, sb.size() == DEPTH);
      check("host_ready", host_ready, sb.size() < DEPTH);
      check("timeout_err", timeout_err, exp_timeout);
      prev_instr = host_instruction;
    end
  end

  // ---------------- control FSM model ----------------
  bit         respond = 1'b1;
  bit         force_busy = 1'b0;
  bit         rand_len = 1'b0;
  int         busy_len = 6;
  int         cur_len = 0;
  bit         pending = 1'b0;
  int         busy_left = 0;
  logic [7:0] prev_f = 8'h00;

  always begin
    @(posedge clk); #3;
    if (!reset) begin
      pending = 1'b0;
      busy_left = 0;
      prev_f = 8'h00;
      fsm_busy = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        busy_left = cur_len;
      end
      if (respond && host_instruction != 8'h00 && prev_f == 8'h00) begin
        pending = 1'b1;
        cur_len = rand_len ? int'($urandom_range(0, 6)) : busy_len;
      end
      prev_f = host_instruction;
      fsm_busy = force_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive_push(input logic [7:0] v, input bit do_flush);
    host_valid = 1'b1;
    host_instr = v;
    flush = do_flush;
    if (reset) begin
      if (do_flush) flush_pending = 1'b1;
      else if (sb.size() < DEPTH && v != 8'h00) sb.push_back(v);
    end
    tick();
    host_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cycles);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < max_cycles) begin
      tick();
      n++;
      if (sb.size() == 0 && !pending && busy_left == 0 && fsm_busy == 1'b0 &&
          host_instruction == 8'h00) quiet++;
      else quiet = 0;
    end
    check("drain_bound", quiet, 4);
  endtask

  logic [7:0] v;
  logic [7:0] b2b [4] = '{8'h41, 8'h95, 8'hDC, 8'h0F};

  initial begin
    // Reset with a push offered: it must be ignored.
    reset = 1'b0;
    host_valid = 1'b1;
    host_instr = 8'h04;
    tick();
    tick();
    host_valid = 1'b0;
    host_instr = 8'h00;
    reset = 1'b1;
    tick();

    // Single issue with a long busy period.
    busy_len = 64;
    drive_push(8'h04, 1'b0);
    wait_quiet(200);

    // Back-to-back pushes issue in order with gaps.
    busy_len = 5;
    for (int i = 0; i < 4; i++) drive_push(b2b[i], 1'b0);
    wait_quiet(200);

    // Fill to full while the FSM is busy, then drain and wrap.
    force_busy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 9; i++) drive_push(8'(1 + $urandom_range(0, 254)), 1'b0);
    check("full_flag", full, 1);
    check("ready_low", host_ready, 0);
    force_busy = 1'b0;
    wait_quiet(400);
    for (int i = 0; i < 8; i++) drive_push(8'(1 + $urandom_range(0, 254)), 1'b0);
    wait_quiet(400);

    // NOP filter, then busy timeout followed by the next entry.
    drive_push(8'h00, 1'b0);
    check("nop_count", count, 0);
    respond = 1'b0;
    drive_push(8'h4C, 1'b0);
    drive_push(8'h23, 1'b0);
    wait_quiet(100);
    check("timeout_sticky", timeout_err, 1);
    respond = 1'b1;

    // Flush with a simultaneous push while one instruction is in flight.
    busy_len = 20;
    drive_push(8'hA1, 1'b0);
    drive_push(8'hB2, 1'b0);
    drive_push(8'hC3, 1'b0);
    drive_push(8'hD4, 1'b0);
    tick();
    tick();
    drive_push(8'hE5, 1'b1);
    check("flush_count", count, 0);
    wait_quiet(100);

    // Randomized traffic with random busy lengths, flushes and one reset.
    rand_len = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      if ($urandom_range(0, 1) == 1) drive_push(v, $urandom_range(0, 19) == 0);
      else tick();
    end
    rand_len = 1'b0;
    wait_quiet(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
